// File: rtl/gun_input_cond.sv
// Light-gun input conditioning: synchronized, debounced trigger plus per-frame hit detection.
// Define GUN_DEBOUNCE_EN to debounce the trigger; otherwise trigger follows the synchronized input.
module gun_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned DETECT_MIN_CYCLES = 16,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger_raw,
  input  logic       sensor_raw,
  input  logic       valid,
  input  logic       frame_tick,
  output logic       trigger,
  output logic       trigger_rise,
  output logic       detect,
  output logic [7:0] shot_count
);

  localparam logic DARK = SENSOR_ACTIVE_LOW;
  localparam int   RW   = $clog2(DETECT_MIN_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DETECT_MIN_CYCLES);

  logic trig_s1_q, trig_s2_q;
  logic sens_s1_q, sens_s2_q;
  logic trig_lvl;
  logic trig_prev_q;
  logic [7:0] shot_q;
  logic [RW-1:0] run_q, run_d;
  logic hit_q, hit_d;
  logic lit;

  // Two-flop synchronizers; the sensor pair idles at the dark level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      sens_s1_q <= DARK;
      sens_s2_q <= DARK;
    end else begin
      trig_s1_q <= trigger_raw;
      trig_s2_q <= trig_s1_q;
      sens_s1_q <= sensor_raw;
      sens_s2_q <= sens_s1_q;
    end
  end

`ifdef GUN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_trig_q, db_trig_d;

  // Count consecutive mismatch cycles; flip the level when the window fills.
  always_comb begin
    db_cnt_d  = '0;
    db_trig_d = db_trig_q;
    if (trig_s2_q != db_trig_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_trig_d = ~db_trig_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      db_trig_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_trig_q <= db_trig_d;
    end
  end

  assign trig_lvl = db_trig_q;
`else
  logic unused_db_cfg;
  assign unused_db_cfg = (DEBOUNCE_CYCLES > 0);
  assign trig_lvl      = trig_s2_q;
`endif

  assign trigger      = trig_lvl;
  assign trigger_rise = trig_lvl & ~trig_prev_q;
  assign shot_count   = shot_q;

  // Remember last level for edge detection; count each press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev_q <= 1'b0;
      shot_q      <= 8'd0;
    end else begin
      trig_prev_q <= trig_lvl;
      if (trigger_rise) begin
        shot_q <= shot_q + 8'd1;
      end
    end
  end

  assign lit = (sens_s2_q == ~SENSOR_ACTIVE_LOW);

  // Lit-run tracking; the frame boundary wins over any same-cycle update.
  always_comb begin
    run_d = run_q;
    hit_d = hit_q;
    if (frame_tick) begin
      run_d = '0;
      hit_d = 1'b0;
    end else if (valid) begin
      if (lit) begin
        if (run_q != RUN_MAX) begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = '0;
      end
      if (run_d == RUN_MAX) begin
        hit_d = 1'b1;
      end
    end
  end

  // Run counter and sticky per-frame hit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
      hit_q <= 1'b0;
    end else begin
      run_q <= run_d;
      hit_q <= hit_d;
    end
  end

  assign detect = hit_q;

endmodule

// File: tb/tb_gun_input_cond.sv
// Directed bench for gun_input_cond.
// Expectations follow GUN_DEBOUNCE_EN the same way the design does.
module tb_gun_input_cond;

  localparam int   DB   = 8;
  localparam int   DM   = 16;
  localparam logic LIT  = 1'b0;
  localparam logic DARK = 1'b1;
`ifdef GUN_DEBOUNCE_EN
  localparam int LAT  = 10;
  localparam int HOLD = 12;
  localparam int BOUNCE_SHOTS = 0;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 4;
  localparam int BOUNCE_SHOTS = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger_raw;
  logic       sensor_raw;
  logic       valid;
  logic       frame_tick;
  logic       trigger;
  logic       trigger_rise;
  logic       detect;
  logic [7:0] shot_count;

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  gun_input_cond #(
    .DEBOUNCE_CYCLES(DB),
    .DETECT_MIN_CYCLES(DM),
    .SENSOR_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trigger_raw(trigger_raw),
    .sensor_raw(sensor_raw),
    .valid(valid),
    .frame_tick(frame_tick),
    .trigger(trigger),
    .trigger_rise(trigger_rise),
    .detect(detect),
    .shot_count(shot_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trigger_rise === 1'b1) rises = rises + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trigger_raw = 1'b0;
    sensor_raw = DARK;
    valid = 1'b0;
    frame_tick = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press_wait(output int k);
    trigger_raw = 1'b1;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (trigger === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_pattern(input logic [63:0] vp, input logic [63:0] lp,
                             input logic [63:0] fp, input int n,
                             output int first_hit);
    first_hit = -1;
    for (int c = 0; c <= n + 1; c++) begin
      sensor_raw = (c < n && lp[c]) ? LIT : DARK;
      valid      = (c >= 2) ? vp[c-2] : 1'b0;
      frame_tick = (c >= 2) ? fp[c-2] : 1'b0;
      step(1);
      if (c >= 2 && detect === 1'b1 && first_hit < 0) first_hit = c - 2;
    end
    valid = 1'b0;
    frame_tick = 1'b0;
    sensor_raw = DARK;
  endtask

  task automatic frame_clear();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trigger_raw = 1'b0;
    sensor_raw = DARK;
    valid = 1'b0;
    frame_tick = 1'b0;
    step(2);
    checks++;
    if (trigger !== 1'b0) begin
      errors++; $display("FAIL reset_trigger got %b want 0", trigger);
    end
    checks++;
    if (trigger_rise !== 1'b0) begin
      errors++; $display("FAIL reset_rise got %b want 0", trigger_rise);
    end
    checks++;
    if (detect !== 1'b0) begin
      errors++; $display("FAIL reset_detect got %b want 0", detect);
    end
    checks++;
    if (shot_count !== 8'd0) begin
      errors++; $display("FAIL reset_shots got %0d want 0", shot_count);
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({trigger, trigger_rise, detect, shot_count} !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_outputs got %b want 0",
               {trigger, trigger_rise, detect, shot_count});
    end
  endtask

  task automatic test_bounce();
    do_reset();
    rises = 0;
    repeat (6) begin
      trigger_raw = 1'b1;
      step(5);
      trigger_raw = 1'b0;
      step(1);
    end
    step(HOLD);
    checks++;
    if (trigger !== 1'b0) begin
      errors++; $display("FAIL bounce_trigger got %b want 0", trigger);
    end
    checks++;
    if (rises !== BOUNCE_SHOTS) begin
      errors++; $display("FAIL bounce_rises got %0d want %0d", rises, BOUNCE_SHOTS);
    end
    checks++;
    if (shot_count !== 8'(BOUNCE_SHOTS)) begin
      errors++;
      $display("FAIL bounce_shots got %0d want %0d", shot_count, BOUNCE_SHOTS);
    end
  endtask

  task automatic test_press();
    int k;
    do_reset();
    rises = 0;
    press_wait(k);
    checks++;
    if (k !== LAT) begin
      errors++; $display("FAIL press_latency got %0d want %0d", k, LAT);
    end
    checks++;
    if (trigger_rise !== 1'b1) begin
      errors++; $display("FAIL press_rise got %b want 1", trigger_rise);
    end
    step(1);
    checks++;
    if (trigger_rise !== 1'b0) begin
      errors++; $display("FAIL press_rise_width got %b want 0", trigger_rise);
    end
    checks++;
    if (shot_count !== 8'd1) begin
      errors++; $display("FAIL press_shots got %0d want 1", shot_count);
    end
    step(HOLD);
    checks++;
    if (rises !== 1 || trigger !== 1'b1) begin
      errors++;
      $display("FAIL press_hold got rises=%0d trig=%b want 1 1", rises, trigger);
    end
    rises = 0;
    trigger_raw = 1'b0;
    step(HOLD);
    checks++;
    if (trigger !== 1'b0) begin
      errors++; $display("FAIL release_trigger got %b want 0", trigger);
    end
    checks++;
    if (rises !== 0) begin
      errors++; $display("FAIL release_rise got %0d want 0", rises);
    end
    checks++;
    if (shot_count !== 8'd1) begin
      errors++; $display("FAIL release_shots got %0d want 1", shot_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      trigger_raw = 1'b1;
      step(HOLD);
      trigger_raw = 1'b0;
      step(HOLD);
      if (p == 255) begin
        checks++;
        if (shot_count !== 8'd255) begin
          errors++; $display("FAIL wrap_255 got %0d want 255", shot_count);
        end
      end
    end
    checks++;
    if (shot_count !== 8'd0) begin
      errors++; $display("FAIL wrap_0 got %0d want 0", shot_count);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    rises = 0;
    trigger_raw = 1'b1;
    step(LAT / 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({trigger, trigger_rise, detect, shot_count} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b want 0",
               {trigger, trigger_rise, detect, shot_count});
    end
    step(2);
    rst_n = 1'b1;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (trigger === 1'b1) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k !== LAT) begin
      errors++; $display("FAIL mid_reset_restart got %0d want %0d", k, LAT);
    end
    step(1);
    checks++;
    if (rises !== 1 || shot_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_rises got %0d/%0d want 1/1", rises, shot_count);
    end
    trigger_raw = 1'b0;
    step(HOLD);
  endtask

  task automatic test_detect();
    int fh;
    logic [63:0] v, l, f;
    v = '1;
    l = '1;
    f = '0;
    run_pattern(v, l, f, 16, fh);
    checks++;
    if (fh !== 15) begin
      errors++; $display("FAIL detect_16 got %0d want 15", fh);
    end
    step(3);
    frame_tick = 1'b1;
    checks++;
    if (detect !== 1'b1) begin
      errors++; $display("FAIL detect_tick_cycle got %b want 1", detect);
    end
    step(1);
    frame_tick = 1'b0;
    checks++;
    if (detect !== 1'b0) begin
      errors++; $display("FAIL detect_after_tick got %b want 0", detect);
    end
    l[15] = 1'b0;
    run_pattern(v, l, f, 31, fh);
    checks++;
    if (fh !== -1) begin
      errors++; $display("FAIL detect_gap got %0d want -1", fh);
    end
    frame_clear();
    l = '1;
    v[15] = 1'b0;
    v[16] = 1'b0;
    v[17] = 1'b0;
    run_pattern(v, l, f, 19, fh);
    checks++;
    if (fh !== 18) begin
      errors++; $display("FAIL detect_hold got %0d want 18", fh);
    end
    frame_clear();
    v = '1;
    f[15] = 1'b1;
    run_pattern(v, l, f, 17, fh);
    checks++;
    if (fh !== -1) begin
      errors++; $display("FAIL tick_priority got %0d want -1", fh);
    end
    frame_clear();
  endtask

  task automatic test_concurrent();
    int k;
    int fh;
    do_reset();
    fork
      press_wait(k);
      run_pattern('1, '1, '0, 16, fh);
    join
    checks++;
    if (k !== LAT) begin
      errors++; $display("FAIL conc_trigger got %0d want %0d", k, LAT);
    end
    checks++;
    if (fh !== 15) begin
      errors++; $display("FAIL conc_detect got %0d want 15", fh);
    end
    trigger_raw = 1'b0;
    frame_clear();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_wrap();
    test_reset_mid();
    test_detect();
    test_concurrent();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
